// File: rtl/tx_wqe_pkg.sv
// tx_wqe_pkg: WQE field layout, type codes and segmenter FSM encoding for the TX path
package tx_wqe_pkg;
    localparam int LEN_LSB   = 0;
    localparam int LEN_W     = 32;
    localparam int VADDR_LSB = 32;
    localparam int VADDR_W   = 64;
    localparam int QPN_LSB   = 96;
    localparam int QPN_W     = 24;
    localparam int OPC_LSB   = 120;
    localparam int OPC_W     = 8;
    localparam int FRESH_BIT = 128;
    localparam logic TYPE_LS = 1'b0;
    localparam logic TYPE_BS = 1'b1;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEG,
        ST_WB,
        ST_CLR
    } seg_state_t;
endpackage

// File: rtl/wqe_segmenter_if.sv
// wqe_segmenter_if: packet descriptor channel from the segmenter to the packet builder
interface wqe_segmenter_if
    import tx_wqe_pkg::*;
#(
    parameter int PMTU_LOG2 = 12
);
    logic                 o_pkt_val;
    logic                 i_pkt_rdy;
    logic [QPN_W-1:0]     o_pkt_qpn;
    logic [OPC_W-1:0]     o_pkt_opcode;
    logic [VADDR_W-1:0]   o_pkt_vaddr;
    logic [PMTU_LOG2:0]   o_pkt_len;
    logic                 o_pkt_first;
    logic                 o_pkt_last;
    modport master (
        output o_pkt_val, o_pkt_qpn, o_pkt_opcode, o_pkt_vaddr, o_pkt_len, o_pkt_first, o_pkt_last,
        input  i_pkt_rdy
    );
    modport slave (
        input  o_pkt_val, o_pkt_qpn, o_pkt_opcode, o_pkt_vaddr, o_pkt_len, o_pkt_first, o_pkt_last,
        output i_pkt_rdy
    );
endinterface

// File: rtl/wqe_segmenter.sv
// wqe_segmenter: splits LS/BS WQEs into PMTU descriptors, writing back BS remainders per quantum
module wqe_segmenter
    import tx_wqe_pkg::*;
#(
    parameter int WQE_WIDTH           = 512,
    parameter int PWQE_BUF_ADDR_WIDTH = 2,
    parameter int PMTU_LOG2           = 12,
    parameter int QUANTUM             = 4
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_wqe_cache_empty,
    output logic                           o_wqe_cache_rd,
    input  logic                           i_wqe_val,
    input  logic                           i_wqe_type,
    input  logic [PWQE_BUF_ADDR_WIDTH-1:0] i_wqe_addr,
    input  logic [WQE_WIDTH-1:0]           i_wqe,
    output logic                           o_pwqe_wb,
    output logic [PWQE_BUF_ADDR_WIDTH-1:0] o_pwqe_addr,
    output logic [WQE_WIDTH-1:0]           o_pwqe,
    output logic                           o_slot_clr,
    output logic [PWQE_BUF_ADDR_WIDTH-1:0] o_slot_clr_addr,
    wqe_segmenter_if.master                pkt
);
    localparam logic [LEN_W-1:0] PMTU = LEN_W'(1) << PMTU_LOG2;
    localparam logic [3:0]       QNT  = 4'(QUANTUM);

    seg_state_t                     r_state, w_next;
    logic [WQE_WIDTH-1:0]           r_wqe;
    logic                           r_bs;
    logic [PWQE_BUF_ADDR_WIDTH-1:0] r_addr;
    logic [3:0]                     r_cnt;
    logic                           r_first;
    logic                           r_rd;

    logic [LEN_W-1:0]     w_len;
    logic [VADDR_W-1:0]   w_vaddr;
    logic                 w_last;
    logic [PMTU_LOG2:0]   w_seg;
    logic                 w_in_seg;
    logic                 w_in_wb;
    logic                 w_in_clr;
    logic                 w_acc;
    logic [WQE_WIDTH-1:0] w_pwqe;

    assign w_len    = r_wqe[LEN_LSB +: LEN_W];
    assign w_vaddr  = r_wqe[VADDR_LSB +: VADDR_W];
    assign w_last   = w_len <= PMTU;
    assign w_seg    = w_last ? w_len[PMTU_LOG2:0] : PMTU[PMTU_LOG2:0];
    assign w_in_seg = r_state == ST_SEG;
    assign w_in_wb  = r_state == ST_WB;
    assign w_in_clr = r_state == ST_CLR;
    assign w_acc    = w_in_seg & pkt.i_pkt_rdy;

    // next state: a final packet ends the WQE; a full BS quantum parks the remainder
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = i_wqe_cache_empty ? ST_IDLE : ST_WAIT;
            ST_WAIT: w_next = i_wqe_val ? ST_SEG : ST_WAIT;
            ST_SEG:  w_next = !w_acc ? ST_SEG :
                              w_last ? (r_bs ? ST_CLR : ST_IDLE) :
                              (r_bs && (r_cnt + 4'd1 == QNT)) ? ST_WB : ST_SEG;
            ST_WB:   w_next = ST_IDLE;
            ST_CLR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        r_state <= rst ? ST_IDLE : w_next;
    end

    // working WQE: captured on fetch, advanced by one segment per accepted descriptor
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wqe   <= '0;
            r_bs    <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_rd <= (r_state == ST_IDLE) && !i_wqe_cache_empty;
            if (r_state == ST_WAIT && i_wqe_val) begin
                r_wqe   <= i_wqe;
                r_bs    <= i_wqe_type == TYPE_BS;
                r_addr  <= i_wqe_addr;
                r_cnt   <= '0;
                r_first <= (i_wqe_type == TYPE_LS) | ~i_wqe[FRESH_BIT];
            end else if (w_acc) begin
                r_wqe[LEN_LSB +: LEN_W]     <= w_len - LEN_W'(w_seg);
                r_wqe[VADDR_LSB +: VADDR_W] <= w_vaddr + VADDR_W'(w_seg);
                r_cnt                       <= r_cnt + 4'd1;
                r_first                     <= 1'b0;
            end
        end
    end

    // write-back image marks the remainder as already started
    always_comb begin
        w_pwqe            = r_wqe;
        w_pwqe[FRESH_BIT] = 1'b1;
    end

    assign o_wqe_cache_rd   = r_rd;
    assign o_pwqe_wb        = w_in_wb;
    assign o_pwqe_addr      = w_in_wb ? r_addr : '0;
    assign o_pwqe           = w_in_wb ? w_pwqe : '0;
    assign o_slot_clr       = w_in_clr;
    assign o_slot_clr_addr  = w_in_clr ? r_addr : '0;
    assign pkt.o_pkt_val    = w_in_seg;
    assign pkt.o_pkt_qpn    = w_in_seg ? r_wqe[QPN_LSB +: QPN_W] : '0;
    assign pkt.o_pkt_opcode = w_in_seg ? r_wqe[OPC_LSB +: OPC_W] : '0;
    assign pkt.o_pkt_vaddr  = w_in_seg ? w_vaddr : '0;
    assign pkt.o_pkt_len    = w_in_seg ? w_seg : '0;
    assign pkt.o_pkt_first  = w_in_seg & r_first;
    assign pkt.o_pkt_last   = w_in_seg & w_last;
endmodule

// File: tb/tb_wqe_segmenter.sv
// tb_wqe_segmenter: scoreboard bench for wqe_segmenter descriptors, write-backs and slot clears
module tb_wqe_segmenter;
    localparam int W  = 512;
    localparam int PL = 12;
    localparam int Q  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          empty = 1'b1;
    logic          rd;
    logic          val = 1'b0;
    logic          typ = 1'b0;
    logic [1:0]    addr = '0;
    logic [W-1:0]  wqe = '0;
    logic          wb;
    logic [1:0]    wb_addr;
    logic [W-1:0]  pwqe;
    logic          clr;
    logic [1:0]    clr_addr;

    wqe_segmenter_if #(.PMTU_LOG2(PL)) pkt_if();

    wqe_segmenter #(.WQE_WIDTH(W), .PWQE_BUF_ADDR_WIDTH(2), .PMTU_LOG2(PL), .QUANTUM(Q)) dut (
        .clk(clk), .rst(rst),
        .i_wqe_cache_empty(empty), .o_wqe_cache_rd(rd),
        .i_wqe_val(val), .i_wqe_type(typ), .i_wqe_addr(addr), .i_wqe(wqe),
        .o_pwqe_wb(wb), .o_pwqe_addr(wb_addr), .o_pwqe(pwqe),
        .o_slot_clr(clr), .o_slot_clr_addr(clr_addr),
        .pkt(pkt_if.master)
    );

    typedef struct {
        int            kind;
        logic [1:0]    addr;
        logic [W-1:0]  pwqe;
        logic [23:0]   qpn;
        logic [7:0]    opc;
        logic [63:0]   va;
        logic [PL:0]   len;
        logic          first;
        logic          last;
    } ev_t;

    ev_t          sb[$];
    int           total = 0;
    int           bad = 0;
    int           rd_cnt = 0;
    int           cyc = 0;
    int           last_str = -1;
    bit           rdy_rand = 1'b0;
    logic [W-1:0] pw_back;
    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic [110:0] pf = '0;

    task automatic chk(input string tag, input logic [W+7:0] obs, input logic [W+7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+7:0] pack_ev(input ev_t e);
        logic [W+1:0] p;
        p = (e.kind == 0) ? (W+2)'({e.qpn, e.opc, e.va, e.len, e.first, e.last}) :
            (e.kind == 1) ? (W+2)'({e.addr, e.pwqe}) : (W+2)'(e.addr);
        return (W+8)'({2'(e.kind), p});
    endfunction

    task automatic expect_ev(input int k, input logic [W+1:0] obs);
        ev_t e;
        if (sb.size() == 0) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_ev kind=%0d obs=%0h exp=none", k, obs);
            end
        end else begin
            e = sb.pop_front();
            chk("event", (W+8)'({2'(k), obs}), pack_ev(e));
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [31:0] len, input logic [63:0] va,
                                        input logic [23:0] qpn, input logic [7:0] opc, input bit nonfresh);
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
        w[31:0]    = len;
        w[95:32]   = va;
        w[119:96]  = qpn;
        w[127:120] = opc;
        w[128]     = nonfresh;
        return w;
    endfunction

    function automatic void model(input logic t, input logic [1:0] a, input logic [W-1:0] w,
                                  output logic [W-1:0] rem);
        logic [31:0] len;
        logic [31:0] seg;
        logic [63:0] va;
        bit          first;
        int          n;
        ev_t         e;
        len   = w[31:0];
        va    = w[95:32];
        first = (t == 1'b0) || !w[128];
        n     = 0;
        rem   = '0;
        for (int k = 0; k < 64; k++) begin
            seg     = (len > 32'd4096) ? 32'd4096 : len;
            e.kind  = 0;
            e.addr  = '0;
            e.pwqe  = '0;
            e.qpn   = w[119:96];
            e.opc   = w[127:120];
            e.va    = va;
            e.len   = seg[PL:0];
            e.first = first;
            e.last  = len <= 32'd4096;
            sb.push_back(e);
            len   = len - seg;
            va    = va + 64'(seg);
            n++;
            first = 1'b0;
            if (e.last) begin
                if (t) begin
                    e.kind = 2;
                    e.addr = a;
                    sb.push_back(e);
                end
                break;
            end
            if (t && n == Q) begin
                rem         = w;
                rem[31:0]   = len;
                rem[95:32]  = va;
                rem[128]    = 1'b1;
                e.kind      = 1;
                e.addr      = a;
                e.pwqe      = rem;
                sb.push_back(e);
                break;
            end
        end
    endfunction

    task automatic fetch(input logic t, input logic [1:0] a, input logic [W-1:0] w, input bit drain);
        int n;
        logic [W-1:0] r;
        n = 0;
        empty = 1'b0;
        while (rd !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_rd", (W+8)'(rd), (W+8)'(1));
        empty = 1'b1;
        @(posedge clk); #1;
        val = 1'b1; typ = t; addr = a; wqe = w;
        model(t, a, w, r);
        pw_back = r;
        @(posedge clk); #1;
        val = 1'b0; typ = ~t; addr = ~a; wqe = '1;
        @(negedge clk);
        chk("first_lat", (W+8)'(pkt_if.o_pkt_val), (W+8)'(1));
        if (drain) begin
            n = 0;
            while (sb.size() > 0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk("drain", (W+8)'(sb.size()), '0);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, (W+8)'({rd, wb, wb_addr, clr, clr_addr, pkt_if.o_pkt_val, pkt_if.o_pkt_qpn,
                         pkt_if.o_pkt_opcode, pkt_if.o_pkt_vaddr, pkt_if.o_pkt_len,
                         pkt_if.o_pkt_first, pkt_if.o_pkt_last}), '0);
        chk({tag, "_pwqe"}, (W+8)'(pwqe), '0);
    endtask

    always @(posedge clk) cyc++;

    initial begin
        pkt_if.i_pkt_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) pkt_if.i_pkt_rdy = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (rd) begin
            rd_cnt++;
            if (last_str >= 0) begin
                total++;
                assert (cyc - last_str >= 2) else begin
                    bad++;
                    $error("FAIL rd_gap obs=%0d exp>=2", cyc - last_str);
                end
            end
        end
        if (!rst && pkt_if.o_pkt_val && pkt_if.i_pkt_rdy)
            expect_ev(0, (W+2)'({pkt_if.o_pkt_qpn, pkt_if.o_pkt_opcode, pkt_if.o_pkt_vaddr,
                                 pkt_if.o_pkt_len, pkt_if.o_pkt_first, pkt_if.o_pkt_last}));
        if (wb) expect_ev(1, (W+2)'({wb_addr, pwqe}));
        if (clr) expect_ev(2, (W+2)'(clr_addr));
        if (!rst && pv && !pr)
            chk("stall_hold", (W+8)'({pkt_if.o_pkt_val, pkt_if.o_pkt_qpn, pkt_if.o_pkt_opcode,
                                      pkt_if.o_pkt_vaddr, pkt_if.o_pkt_len, pkt_if.o_pkt_first,
                                      pkt_if.o_pkt_last}), (W+8)'({1'b1, pf}));
        if (wb || clr) last_str = cyc;
        pv = pkt_if.o_pkt_val && !rst;
        pr = pkt_if.i_pkt_rdy;
        pf = {pkt_if.o_pkt_qpn, pkt_if.o_pkt_opcode, pkt_if.o_pkt_vaddr, pkt_if.o_pkt_len,
              pkt_if.o_pkt_first, pkt_if.o_pkt_last};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int rd0;
        logic [W-1:0] pw;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        rd0 = rd_cnt;
        repeat (10) @(posedge clk);
        #1;
        val = 1'b1; typ = 1'b1; addr = 2'd3; wqe = mk(32'd100, 64'h40, 24'h1, 8'h2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        val = 1'b0;
        repeat (37) @(posedge clk);
        chk("no_rd_empty", (W+8)'(rd_cnt - rd0), '0);
        #1;
        empty = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rd_after_empty", (W+8)'(rd), (W+8)'(1));
        fetch(1'b0, 2'd0, mk(32'd10000, 64'h1000, 24'hABCDEF, 8'h0A, 1'b1), 1'b1);
        chk("rd_once", (W+8)'(rd_cnt - rd0), (W+8)'(1));

        fetch(1'b1, 2'd2, mk(32'd20480, 64'hFFFF_FFFF_FFFF_E000, 24'h123456, 8'h11, 1'b0), 1'b1);
        pw = pw_back;
        chk("pwqe_len", (W+8)'(pw[31:0]), (W+8)'(32'd4096));
        chk("pwqe_va", (W+8)'(pw[95:32]), (W+8)'(64'h2000));
        fetch(1'b1, 2'd2, pw, 1'b1);

        fetch(1'b1, 2'd1, mk(32'd0, 64'h5000, 24'h000777, 8'h22, 1'b0), 1'b1);

        fetch(1'b1, 2'd0, mk(32'd16384, 64'h8000, 24'h0000AA, 8'h33, 1'b1), 1'b1);

        rdy_rand = 1'b1;
        fetch(1'b0, 2'd3, mk(32'd10000, 64'h1000, 24'hABCDEF, 8'h0A, 1'b0), 1'b1);
        fetch(1'b1, 2'd1, mk(32'd20481, 64'h10_0000, 24'h00BEEF, 8'h44, 1'b0), 1'b1);
        rdy_rand = 1'b0;
        @(posedge clk); #2;
        pkt_if.i_pkt_rdy = 1'b1;
        repeat (4) @(posedge clk);

        fetch(1'b1, 2'd3, mk(32'd20480, 64'h9000, 24'h0C0FFE, 8'h55, 1'b0), 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        pkt_if.i_pkt_rdy = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        chk_reset_outs("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        pkt_if.i_pkt_rdy = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("post_reset");
        chk("post_reset_sb", (W+8)'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
